// File: rtl/rx_baud_tick_generator_pkg.sv
// Shared UART rate constants and elaboration-time helpers for the baud tick generators.
// The receiver and transmitter tick users take their default rates from here.
package rx_baud_tick_generator_pkg;

    localparam int unsigned DefaultBaudrate   = 32'd115200;
    localparam int unsigned DefaultFrequency  = 32'd100000000;
    localparam int unsigned DefaultOversample = 32'd16;

    // Round-to-nearest divisor. The math is done in 64 bits so that OVERSAMPLE*baudrate
    // cannot wrap. A zero rate returns 0 so that the caller's range check reports it.
    function automatic longint unsigned calc_div(input longint unsigned freq,
                                                 input longint unsigned rate);
        if (rate == 64'd0) begin
            return 64'd0;
        end
        return (freq + rate / 64'd2) / rate;
    endfunction

    // Counter width for a modulo-v counter. Never narrower than one bit.
    function automatic int unsigned min1_clog2(input longint unsigned v);
        if (v <= 64'd1) begin
            return 1;
        end
        return $clog2(v);
    endfunction

endpackage

// File: rtl/rx_baud_tick_generator.sv
// Free-running OVERSAMPLE x baud sample strobe for the UART receiver.
// Integer mode uses a round-to-nearest divider; fractional mode uses an exact phase accumulator.
module rx_baud_tick_generator
    import rx_baud_tick_generator_pkg::*;
#(
    parameter int unsigned baudrate   = DefaultBaudrate,
    parameter int unsigned frequency  = DefaultFrequency,
    parameter int unsigned OVERSAMPLE = DefaultOversample,
    parameter int unsigned FRACTIONAL = 0
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam longint unsigned INC = 64'(OVERSAMPLE) * 64'(baudrate);
    localparam longint unsigned MOD = 64'(frequency);
    localparam longint unsigned DIV = calc_div(MOD, INC);

    if (INC == 64'd0 || INC > MOD) begin : g_bad_rate
        $fatal(1, "rx_baud_tick_generator: OVERSAMPLE*baudrate must lie in (0, frequency]");
    end

    if (FRACTIONAL > 1) begin : g_bad_mode
        $fatal(1, "rx_baud_tick_generator: FRACTIONAL must be 0 or 1");
    end

    if (FRACTIONAL == 0 && DIV < 64'd1) begin : g_bad_div
        $fatal(1, "rx_baud_tick_generator: integer divisor rounds to zero");
    end

    logic tick_d;
    logic tick_q;

    if (FRACTIONAL == 0) begin : g_int
        localparam int unsigned CntW = min1_clog2(DIV);
        localparam logic [CntW-1:0] CntMax = CntW'(DIV - 64'd1);

        logic [CntW-1:0] cnt_q;
        logic [CntW-1:0] cnt_d;

        always_comb begin
            cnt_d  = cnt_q + 1'b1;
            tick_d = 1'b0;
            if (cnt_q == CntMax) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end else begin : g_frac
        // One spare bit so that acc+INC (< 2*MOD) never wraps.
        localparam int unsigned AccW = $clog2(MOD) + 1;
        localparam logic [AccW-1:0] IncA = AccW'(INC);
        localparam logic [AccW-1:0] ModA = AccW'(MOD);

        logic [AccW-1:0] acc_q;
        logic [AccW-1:0] acc_d;
        logic [AccW-1:0] acc_sum;

        always_comb begin
            acc_sum = acc_q + IncA;
            acc_d   = acc_sum;
            tick_d  = 1'b0;
            if (acc_sum >= ModA) begin
                acc_d  = acc_sum - ModA;
                tick_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_rx_baud_tick_generator.sv
// Scoreboard bench for rx_baud_tick_generator: five configurations, each with its own reset,
// checked against hand-derived tick cycle numbers counted from reset release.
module tb_rx_baud_tick_generator;

    localparam int NInst = 5;

    logic clk;
    logic [NInst-1:0] rst;
    logic [NInst-1:0] tck;

    int exp_q[NInst][$];
    int n[NInst];
    int last_n[NInst];
    int tick_cnt[NInst];
    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: defaults, DIV=54
    rx_baud_tick_generator u_def (
        .clk   (clk),
        .reset (rst[0]),
        .tick  (tck[0])
    );

    // 1: DIV=10
    rx_baud_tick_generator #(
        .baudrate   (32'd1),
        .frequency  (32'd160),
        .OVERSAMPLE (32'd16),
        .FRACTIONAL (32'd0)
    ) u_small (
        .clk   (clk),
        .reset (rst[1]),
        .tick  (tck[1])
    );

    // 2: DIV=1
    rx_baud_tick_generator #(
        .baudrate   (32'd1),
        .frequency  (32'd16),
        .OVERSAMPLE (32'd16),
        .FRACTIONAL (32'd0)
    ) u_one (
        .clk   (clk),
        .reset (rst[2]),
        .tick  (tck[2])
    );

    // 3: fractional, INC=16, MOD=35
    rx_baud_tick_generator #(
        .baudrate   (32'd1),
        .frequency  (32'd35),
        .OVERSAMPLE (32'd16),
        .FRACTIONAL (32'd1)
    ) u_frac (
        .clk   (clk),
        .reset (rst[3]),
        .tick  (tck[3])
    );

    // 4: fractional, default rates
    rx_baud_tick_generator #(
        .FRACTIONAL (32'd1)
    ) u_frac_def (
        .clk   (clk),
        .reset (rst[4]),
        .tick  (tck[4])
    );

    // n[i] = number of rising edges since reset release (0 while the last edge saw reset).
    always @(posedge clk) begin
        for (int i = 0; i < NInst; i++) begin
            n[i] <= rst[i] ? 0 : n[i] + 1;
        end
    end

    // Monitor: every observed tick pops the scoreboard and must land on the expected cycle.
    always @(negedge clk) begin
        int e;
        int sp;
        for (int i = 0; i < NInst; i++) begin
            if (n[i] == 0) begin
                checks++;
                if (tck[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_quiet[%0d]: tick=%b, required 0", i, tck[i]);
                end
            end else if (tck[i] === 1'b1) begin
                tick_cnt[i]++;
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick[%0d]: tick at cycle %0d, none expected",
                             i, n[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (e != n[i]) begin
                        errors++;
                        $display("FAIL tick_cycle[%0d]: tick at cycle %0d, required cycle %0d",
                                 i, n[i], e);
                    end
                end
                if (i >= 3 && last_n[i] != 0) begin
                    sp = n[i] - last_n[i];
                    checks++;
                    if ((i == 3 && sp != 2 && sp != 3) || (i == 4 && sp != 54 && sp != 55)) begin
                        errors++;
                        $display("FAIL spacing[%0d]: spacing %0d at cycle %0d, required %s",
                                 i, sp, n[i], (i == 3) ? "2 or 3" : "54 or 55");
                    end
                end
                last_n[i] = n[i];
            end
        end
    end

    // Release reset, run ncyc edges, reassert reset and audit the scoreboard.
    task automatic run_phase(input int i, input int ncyc, input int exp_ticks,
                             input string name);
        tick_cnt[i] = 0;
        last_n[i]   = 0;
        rst[i]      = 1'b0;
        repeat (ncyc) @(posedge clk);
        #2 rst[i] = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q[i].size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected ticks not seen, required 0 (next at %0d)",
                     name, exp_q[i].size(), exp_q[i][0]);
            exp_q[i].delete();
        end
        checks++;
        if (tick_cnt[i] != exp_ticks) begin
            errors++;
            $display("FAIL %s_count: %0d ticks, required %0d", name, tick_cnt[i], exp_ticks);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    int frac_tbl[16] = '{3, 5, 7, 9, 11, 14, 16, 18, 20, 22, 25, 27, 29, 31, 33, 35};

    initial begin
        longint unsigned inc_l;
        longint unsigned mod_l;
        checks = 0;
        errors = 0;
        for (int i = 0; i < NInst; i++) begin
            n[i]        = 0;
            last_n[i]   = 0;
            tick_cnt[i] = 0;
        end
        rst = '1;
        repeat (5) @(posedge clk);
        #2;

        // Defaults: ticks on cycles 54, 108, 162.
        exp_q[0].push_back(54);
        exp_q[0].push_back(108);
        exp_q[0].push_back(162);
        run_phase(0, 200, 3, "div54");

        // Reset 30 cycles into the second period, then a fresh full period.
        exp_q[0].push_back(54);
        run_phase(0, 84, 1, "mid_reset_pre");
        exp_q[0].push_back(54);
        run_phase(0, 60, 1, "mid_reset_post");

        // DIV=10: 100 ticks in 1000 cycles.
        for (int k = 1; k <= 100; k++) begin
            exp_q[1].push_back(10 * k);
        end
        run_phase(1, 1000, 100, "div10");

        // DIV=1: high on every cycle.
        for (int k = 1; k <= 20; k++) begin
            exp_q[2].push_back(k);
        end
        run_phase(2, 20, 20, "div1");

        // 16/35 fractional: pattern repeats exactly every 35 cycles.
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 16; k++) begin
                exp_q[3].push_back(frac_tbl[k] + 35 * w);
            end
        end
        run_phase(3, 70, 32, "frac35");

        // Default fractional: tick on cycle k whenever floor(k*INC/MOD) steps.
        inc_l = 64'd16 * 64'd115200;
        mod_l = 64'd100000000;
        for (int k = 1; k <= 50000; k++) begin
            if ((longint'(k) * inc_l) / mod_l != (longint'(k - 1) * inc_l) / mod_l) begin
                exp_q[4].push_back(k);
            end
        end
        run_phase(4, 50000, 921, "frac_def");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_baud_tick_generator.md
# rx_baud_tick_generator

Free-running sample-tick generator for the UART receiver. It divides the system clock down to OVERSAMPLE × baud rate, which is 16× in the standard configuration. It emits a one-clock `tick` pulse at that rate, and the receiver FSM uses each pulse as its sampling strobe for the start, data and stop bit counters. The block has no data path, only a counter or phase accumulator and a registered pulse output.

## Interface
- `baudrate`, default 32'd115200: line rate in bits/s.
- `frequency`, default 32'd100000000: `clk` frequency in Hz.
- `OVERSAMPLE`, default 16: ticks per bit period.
- `FRACTIONAL`, default 0:
  - 0 selects the integer divider.
  - 1 selects the phase accumulator, which gives an exact average rate.
- `clk`, input, 1 bit: system clock; all logic is on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `tick`, output, 1 bit: registered one-cycle strobe at OVERSAMPLE × baudrate.
- One clock; reset is synchronous and active-high.

## Operation
- **Reset value.** `tick` = 0 and the counter/accumulator = 0.
- **Integer mode (FRACTIONAL=0).**
  - Divisor: DIV = (frequency + OVERSAMPLE·baudrate/2) / (OVERSAMPLE·baudrate), computed at elaboration (round to nearest). Defaults give DIV = 54.
  - Counter width: max(1, $clog2(DIV)).
  - Each clock, if count == DIV−1: count ← 0, tick ← 1. Otherwise: count ← count+1, tick ← 0.
- **Fractional mode (FRACTIONAL=1).**
  - Constants: INC = OVERSAMPLE·baudrate, MOD = frequency.
  - Accumulator range is [0, MOD). Its width is $clog2(MOD)+1 so that acc+INC cannot overflow.
  - Each clock, if acc+INC ≥ MOD: acc ← acc+INC−MOD, tick ← 1. Otherwise: acc ← acc+INC, tick ← 0.
  - All arithmetic is unsigned, performed at the accumulator width.
- **Elaboration errors.** Elaboration fails via a generate-time check when:
  - OVERSAMPLE·baudrate > frequency, or
  - in integer mode, DIV < 1.
- **Free running.** No enable input. `tick` runs continuously whenever `reset` is low, independent of line activity.

## Timing
- **Integer mode.**
  - The first `tick` is high for the single cycle following the DIV-th rising edge after `reset` deasserts.
  - After that, `tick` repeats every DIV cycles exactly and is never high for two consecutive cycles, unless DIV = 1.
  - With DIV = 1, `tick` is constant 1 from the first edge after reset.
- **Fractional mode.**
  - Tick spacing is ⌊MOD/INC⌋ or ⌈MOD/INC⌉ cycles.
  - Exactly INC ticks occur in every MOD consecutive cycles, counted from reset release.
- **Reset mid-operation.** Asserting `reset` on any edge clears the state; `tick` is 0 on the following cycle. The next `tick` then arrives with first-tick timing, with no partial period.
- **Latency.** `tick` is a registered output and there is no combinational path from any input. Clock-to-output latency is one flop.

## Structure
- The default baudrate, frequency and OVERSAMPLE constants belong in the shared UART package. They are shared with the receiver and transmitter tick users.
- A single flat module with a generate branch per mode; no sub-module.
- DIV, INC, MOD and the widths are localparams.

## Test plan
- **Default parameters, integer mode.** Reset for 5 cycles, then release. Required: first `tick` on cycle 54, then ticks at 108 and 162; each is one cycle wide; 0 at all other cycles.
- **Small divider.** frequency=160, baudrate=1, OVERSAMPLE=16, so DIV=10. Required: ticks every 10 cycles; 100 ticks over 1000 cycles.
- **Reset mid-period.** Assert `reset` 30 cycles into a period with DIV=54. Required: `tick` stays 0 during reset; the next tick arrives 54 cycles after release.
- **DIV = 1.** frequency=16, baudrate=1. Required: `tick` = 1 on every cycle after the first post-reset edge; 0 while reset is held.
- **Fractional mode.** frequency=35, baudrate=1, FRACTIONAL=1. Required:
  - 16 ticks per 35-cycle window;
  - spacings only 2 or 3;
  - accumulator returns to 0 after 35 cycles.
- **Fractional mode, default rates.** Run 100000 cycles. Required: 1843 ticks (±1); spacing only 54 or 55.
